// File: rtl/detect_seq_pkg.sv
// Shared types and default sizing for the parameterised serial sequence detector.
package detect_seq_pkg;

    localparam int DEFAULT_MAX_LEN = 8;
    localparam int DEFAULT_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DET  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_history_reg.sv
// Serial history shift register with a fill counter that saturates at the active pattern length.
// Also exports the shifted/incremented look-ahead values so the caller can match on the incoming bit.
module seq_history_reg #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift,
    input  logic               bit_in,
    input  logic [LEN_W-1:0]   len,
    input  logic               zero_fill,
    output logic [MAX_LEN-1:0] history_next,
    output logic [LEN_W-1:0]   fill_next
);

    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   fill_q, fill_d;

    assign history_next = {history_q[MAX_LEN-2:0], bit_in};
    assign fill_next    = (fill_q >= len) ? len : fill_q + LEN_W'(1);

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        if (clear) begin
            history_d = '0;
            fill_d    = '0;
        end else if (shift) begin
            history_d = history_next;
            fill_d    = zero_fill ? '0 : fill_next;
        end
    end

    // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            history_q <= '0;
            fill_q    <= '0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/detect_sequence_param_fsm.sv
// Runtime-configurable serial pattern detector (IDLE/HUNT/DET) with overlap control.
// Define DETECT_COUNT_EN to add the saturating match_count output.
module detect_sequence_param_fsm
    import detect_seq_pkg::*;
#(
    parameter int MAX_LEN   = DEFAULT_MAX_LEN,
    parameter int CNT_W     = DEFAULT_CNT_W,
    localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               a,
    output logic               detected,
    output logic               armed
`ifdef DETECT_COUNT_EN
   ,output logic [CNT_W-1:0]   match_count
`endif
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               detected_q;
    logic               armed_q;

    logic               hist_clear;
    logic               hist_shift;
    logic               zero_fill;
    logic [MAX_LEN-1:0] history_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] len_mask;
    logic               cfg_ok;
    logic               match;

    seq_history_reg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_history (
        .clk          (clk),
        .rst          (rst),
        .clear        (hist_clear),
        .shift        (hist_shift),
        .bit_in       (a),
        .len          (len_q),
        .zero_fill    (zero_fill),
        .history_next (history_next),
        .fill_next    (fill_next)
    );

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign cfg_ok = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
    // Match looks at the history/fill as they will be once the incoming bit is absorbed.
    assign match  = (fill_next >= len_q) && (((history_next ^ pattern_q) & len_mask) == '0);

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        len_d      = len_q;
        overlap_d  = overlap_q;
        hist_clear = 1'b0;
        hist_shift = 1'b0;
        zero_fill  = 1'b0;
        if (cfg_load) begin
            // A bit arriving with cfg_load is dropped along with the old history.
            pattern_d  = cfg_pattern;
            len_d      = cfg_len;
            overlap_d  = cfg_overlap;
            hist_clear = 1'b1;
            state_d    = cfg_ok ? HUNT : IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                HUNT, DET: begin
                    state_d = HUNT;
                    if (in_valid) begin
                        hist_shift = 1'b1;
                        if (match) begin
                            state_d   = DET;
                            zero_fill = !overlap_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pattern_q  <= '0;
            len_q      <= '0;
            overlap_q  <= 1'b0;
            detected_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            overlap_q  <= overlap_d;
            detected_q <= (state_d == DET);
            armed_q    <= (state_d != IDLE);
        end
    end

    assign detected = detected_q;
    assign armed    = armed_q;

`ifdef DETECT_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (cfg_load) begin
            count_d = '0;
        end else if (state_d == DET && count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`endif

endmodule

// File: tb/tb_detect_sequence_param_fsm.sv
// Directed scoreboard bench for detect_sequence_param_fsm; count checks enabled with DETECT_COUNT_EN.
module tb_detect_sequence_param_fsm;

    localparam int TB_MAX_LEN = 8;
    localparam int TB_CNT_W   = 2;
    localparam int TB_LEN_W   = $clog2(TB_MAX_LEN + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cfg_load;
    logic [TB_MAX_LEN-1:0] cfg_pattern;
    logic [TB_LEN_W-1:0]   cfg_len;
    logic                  cfg_overlap;
    logic                  in_valid;
    logic                  a;
    logic                  detected;
    logic                  armed;
    logic [TB_CNT_W-1:0]   match_count;

    typedef struct {
        string tag;
        logic  det;
        logic  arm;
        int    cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic s_bits [10];

    always #5 clk = ~clk;

    detect_sequence_param_fsm #(
        .MAX_LEN (TB_MAX_LEN),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .a           (a),
        .detected    (detected),
        .armed       (armed)
`ifdef DETECT_COUNT_EN
       ,.match_count (match_count)
`endif
    );

`ifndef DETECT_COUNT_EN
    assign match_count = '0;
`endif

    task automatic set_cfg(input logic [TB_MAX_LEN-1:0] p, input int len, input logic ov);
        cfg_pattern = p;
        cfg_len     = TB_LEN_W'(len);
        cfg_overlap = ov;
    endtask

    task automatic compare_front();
        exp_t                e;
        logic [TB_CNT_W-1:0] ecnt;
        e    = sb.pop_front();
        ecnt = e.cnt[TB_CNT_W-1:0];
        checks++;
        assert (detected === e.det) else begin
            errors++;
            $error("FAIL %s.detected observed=%b expected=%b", e.tag, detected, e.det);
        end
        checks++;
        assert (armed === e.arm) else begin
            errors++;
            $error("FAIL %s.armed observed=%b expected=%b", e.tag, armed, e.arm);
        end
`ifdef DETECT_COUNT_EN
        checks++;
        assert (match_count === ecnt) else begin
            errors++;
            $error("FAIL %s.match_count observed=%0d expected=%0d", e.tag, match_count, ecnt);
        end
`endif
    endtask

    // One clock per step: drive at negedge, push expectation, sample at the following negedge.
    task automatic step(input string tag, input logic r, input logic ld, input logic v,
                        input logic b, input logic e_det, input logic e_arm, input int e_cnt);
        exp_t e;
        rst      = r;
        cfg_load = ld;
        in_valid = v;
        a        = b;
        e.tag = tag;
        e.det = e_det;
        e.arm = e_arm;
        e.cnt = e_cnt;
        sb.push_back(e);
        @(negedge clk);
        compare_front();
        if (ld) begin
            cfg_pattern = TB_MAX_LEN'($urandom);
            cfg_len     = TB_LEN_W'($urandom);
            cfg_overlap = ~cfg_overlap;
        end
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; a = 1'b0;
        set_cfg(8'h00, 0, 1'b0);
        @(negedge clk);

        step("reset", 1, 0, 0, 0, 0, 0, 0);
        set_cfg(8'b0011_0011, 6, 1'b1);
        step("reset_over_load", 1, 1, 1, 1, 0, 0, 0);

        // Overlapping 110011 detector.
        s_bits = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        set_cfg(8'b0011_0011, 6, 1'b1);
        step("ov_load", 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("ov_bit%0d", i + 1), 0, 0, 1, s_bits[i],
                 (i == 5 || i == 9), 1, (i < 5) ? 0 : (i < 9) ? 1 : 2);
        end
        step("ov_idle", 0, 0, 0, 1, 0, 1, 2);

        // Same stream, non-overlapping.
        set_cfg(8'b0011_0011, 6, 1'b0);
        step("nov_load", 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("nov_bit%0d", i + 1), 0, 0, 1, s_bits[i],
                 (i == 5), 1, (i < 5) ? 0 : 1);
        end

        // 1010 with in_valid gaps carrying junk bits.
        set_cfg(8'b0000_1010, 4, 1'b1);
        step("gap_load",  0, 1, 0, 0, 0, 1, 0);
        step("gap_v1",    0, 0, 1, 1, 0, 1, 0);
        step("gap_x1",    0, 0, 0, 1, 0, 1, 0);
        step("gap_v2",    0, 0, 1, 0, 0, 1, 0);
        step("gap_x2",    0, 0, 0, 1, 0, 1, 0);
        step("gap_v3",    0, 0, 1, 1, 0, 1, 0);
        step("gap_x3",    0, 0, 0, 1, 0, 1, 0);
        step("gap_v4",    0, 0, 1, 0, 1, 1, 1);
        step("det_stall", 0, 0, 0, 1, 0, 1, 1);
        step("resume_v5", 0, 0, 1, 1, 0, 1, 1);
        step("resume_v6", 0, 0, 1, 0, 1, 1, 2);

        // Illegal lengths leave the detector unarmed.
        set_cfg(8'hFF, 1, 1'b1);
        step("len1_load", 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("len1_bit%0d", i + 1), 0, 0, 1, 1, 0, 0, 0);
        end
        set_cfg(8'hFF, TB_MAX_LEN + 1, 1'b1);
        step("len9_load", 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step($sformatf("len9_bit%0d", i + 1), 0, 0, 1, 1, 0, 0, 0);
        end

        // cfg_load collides with the completing bit.
        set_cfg(8'b0000_1010, 4, 1'b0);
        step("col_load", 0, 1, 0, 0, 0, 1, 0);
        step("col_b1",   0, 0, 1, 1, 0, 1, 0);
        step("col_b2",   0, 0, 1, 0, 0, 1, 0);
        step("col_b3",   0, 0, 1, 1, 0, 1, 0);
        step("col_b4",   0, 0, 1, 0, 1, 1, 1);
        step("col_b5",   0, 0, 1, 1, 0, 1, 1);
        step("col_b6",   0, 0, 1, 0, 0, 1, 1);
        step("col_b7",   0, 0, 1, 1, 0, 1, 1);
        set_cfg(8'b0000_1010, 4, 1'b0);
        step("col_reload_b8", 0, 1, 1, 0, 0, 1, 0);
        step("col_f1",   0, 0, 1, 1, 0, 1, 0);
        step("col_f2",   0, 0, 1, 0, 0, 1, 0);
        step("col_f3",   0, 0, 1, 1, 0, 1, 0);
        step("col_f4",   0, 0, 1, 0, 1, 1, 1);

        // Saturating counter on back-to-back 11 matches, then reset mid-stream.
        set_cfg(8'b0000_0011, 2, 1'b1);
        step("sat_load", 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("sat_bit%0d", i + 1), 0, 0, 1, 1,
                 (i >= 1), 1, (i < 3) ? i : 3);
        end
        step("sat_rst",      1, 0, 1, 1, 0, 0, 0);
        step("post_rst_bit", 0, 0, 1, 1, 0, 0, 0);
        step("post_rst_bit2", 0, 0, 1, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
